// File: rtl/prism_cnt_shift_bank.sv
// prism_cnt_shift_bank: down-counter bank and programmable shift register with W1C status and irq
module prism_cnt_shift_bank #(
  parameter int NUM_CNT = 2,
  parameter int CNT_W   = 24,
  parameter int SHIFT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exec,
  input  logic [NUM_CNT-1:0] ctl_load,
  input  logic [NUM_CNT-1:0] ctl_dec,
  input  logic               ctl_shift,
  input  logic               ser_in,
  output logic               ser_out,
  output logic [NUM_CNT-1:0] cnt_zero,
  output logic               shift_done,
  input  logic [5:0]         reg_addr,
  input  logic               reg_wr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               irq
);
  localparam logic [3:0] CMASK = 4'((1 << NUM_CNT) - 1);
  localparam logic [4:0] LMAX  = 5'(SHIFT_W - 1);

  logic               dir, en_sh, st_sh, shift_ev, frame_end, wr_ctrl, wr_stat, wr_sd;
  logic [4:0]         len, bcnt;
  logic [3:0]         en_cnt, ar, st_cnt, ev;
  logic [SHIFT_W-1:0] shreg, shreg_nx, lmask, sh_r;
  logic [CNT_W-1:0]   cnt [NUM_CNT];
  logic [CNT_W-1:0]   pre [NUM_CNT];
  logic               unused_bits;

  assign unused_bits = ^reg_wdata;
  assign wr_ctrl     = reg_wr && reg_addr == 6'h00;
  assign wr_stat     = reg_wr && reg_addr == 6'h04;
  assign wr_sd       = reg_wr && reg_addr == 6'h08;
  // a SHIFT_DATA write overrides a coincident shift, so that shift never completes a frame
  assign shift_ev    = exec && ctl_shift && !wr_sd;
  assign frame_end   = shift_ev && bcnt == len;
  assign sh_r        = shreg >> len;
  assign ser_out     = dir ? shreg[0] : sh_r[0];
  assign shreg_nx    = dir ? (shreg & ~lmask) | ((shreg >> 1) & (lmask >> 1)) | (SHIFT_W'(ser_in) << len)
                           : {shreg[SHIFT_W-2:0], ser_in};

  // bit positions taking part in an LSB-first shift (at or below the programmed length)
  always_comb begin
    lmask = '0;
    for (int k = 0; k < SHIFT_W; k++) lmask[k] = k <= int'(len);
  end

  // per-counter zero flag and zero-crossing / auto-reload events
  always_comb begin
    ev = '0;
    cnt_zero = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_zero[i] = cnt[i] == '0;
      ev[i] = exec && ctl_dec[i] && !ctl_load[i] && (cnt[i] == CNT_W'(1) || (cnt[i] == '0 && ar[i]));
    end
  end

  // control register, sticky status (set beats clear), shifter and registered irq
  always_ff @(posedge clk) begin
    if (rst) begin
      dir <= 1'b0;
      len <= '0;
      en_cnt <= '0;
      en_sh <= 1'b0;
      ar <= '0;
      st_cnt <= '0;
      st_sh <= 1'b0;
      shift_done <= 1'b0;
      irq <= 1'b0;
      shreg <= '0;
      bcnt <= '0;
    end else begin
      if (wr_ctrl) begin
        dir <= reg_wdata[0];
        len <= reg_wdata[12:8] > LMAX ? LMAX : reg_wdata[12:8];
        en_cnt <= reg_wdata[19:16] & CMASK;
        en_sh <= reg_wdata[20];
        ar <= reg_wdata[27:24] & CMASK;
      end
      st_cnt <= (st_cnt & ~(wr_stat ? reg_wdata[3:0] : 4'h0)) | ev;
      st_sh <= (st_sh & !(wr_stat && reg_wdata[4])) | frame_end;
      shift_done <= frame_end;
      irq <= |(st_cnt & en_cnt) | (st_sh & en_sh);
      if (wr_sd) begin
        shreg <= reg_wdata[SHIFT_W-1:0];
        bcnt <= '0;
      end else if (shift_ev) begin
        shreg <= shreg_nx;
        bcnt <= frame_end ? 5'd0 : bcnt + 5'd1;
      end
    end
  end

  // preload registers and down-counters; load beats decrement, no wrap below zero
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rst) begin
        cnt[i] <= '0;
        pre[i] <= '0;
      end else begin
        if (reg_wr && reg_addr == 6'(16 + 4 * i)) pre[i] <= reg_wdata[CNT_W-1:0];
        if (exec) begin
          if (ctl_load[i]) cnt[i] <= pre[i];
          else if (ctl_dec[i] && cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
          else if (ev[i]) cnt[i] <= pre[i];
        end
      end
    end
  end

  // register read mux; unmapped addresses read zero
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      6'h00:   reg_rdata = {4'b0, ar, 3'b0, en_sh, en_cnt, 3'b0, len, 7'b0, dir};
      6'h04:   reg_rdata = {19'b0, bcnt, 3'b0, st_sh, st_cnt};
      6'h08:   reg_rdata = 32'(shreg);
      default: reg_rdata = '0;
    endcase
    for (int i = 0; i < NUM_CNT; i++) begin
      if (reg_addr == 6'(16 + 4 * i)) reg_rdata = 32'(pre[i]);
      if (reg_addr == 6'(32 + 4 * i)) reg_rdata = 32'(cnt[i]);
    end
  end
endmodule

// File: tb/tb_prism_cnt_shift_bank.sv
// tb_prism_cnt_shift_bank: table-driven vectors plus a hand-written mid-frame reset sequence
module tb_prism_cnt_shift_bank;
  localparam logic [5:0] CT = 6'h00, ST = 6'h04, SD = 6'h08, P0 = 6'h10, P1 = 6'h14, C0 = 6'h20, C1 = 6'h24;
  localparam logic [31:0] M = 32'hFFFF_FFFF;
  localparam logic [4:0] F_SO = 5'b10000, F_SD = 5'b01000, F_IRQ = 5'b00100, F_Z = 5'b00011;

  logic        clk = 0, rst = 1, exec = 0, ctl_shift = 0, ser_in = 0, reg_wr = 0;
  logic [1:0]  ctl_load = 0, ctl_dec = 0, cnt_zero;
  logic        ser_out, shift_done, irq;
  logic [5:0]  reg_addr = 0;
  logic [31:0] reg_wdata = 0, reg_rdata;
  int          n_run = 0, n_fail = 0;

  prism_cnt_shift_bank dut (
    .clk(clk), .rst(rst), .exec(exec), .ctl_load(ctl_load), .ctl_dec(ctl_dec),
    .ctl_shift(ctl_shift), .ser_in(ser_in), .ser_out(ser_out), .cnt_zero(cnt_zero),
    .shift_done(shift_done), .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ex; logic [1:0] ld, dc; logic sh, si, wr;
    logic [5:0] wa; logic [31:0] wd;
    logic [5:0] ra; logic [31:0] er, rm;
    logic [4:0] ef, fm;
  } vec_t;
  vec_t tbl[$];

  function automatic void v(input logic ex, input logic [1:0] ld, dc, input logic sh, si, wr,
                            input logic [5:0] wa, input logic [31:0] wd, input logic [5:0] ra,
                            input logic [31:0] er, rm, input logic [4:0] ef, fm);
    vec_t t;
    t.ex = ex; t.ld = ld; t.dc = dc; t.sh = sh; t.si = si; t.wr = wr; t.wa = wa; t.wd = wd;
    t.ra = ra; t.er = er; t.rm = rm; t.ef = ef; t.fm = fm;
    tbl.push_back(t);
  endfunction
  function automatic void w(input logic [5:0] a, input logic [31:0] d);
    v(0, 0, 0, 0, 0, 1, a, d, 0, 0, 0, 0, 0);
  endfunction
  function automatic void c(input logic ex, input logic [1:0] ld, dc, input logic sh, si,
                            input logic [5:0] ra, input logic [31:0] er, rm, input logic [4:0] ef, fm);
    v(ex, ld, dc, sh, si, 0, 0, 0, ra, er, rm, ef, fm);
  endfunction
  function automatic void r(input logic [5:0] ra, input logic [31:0] er, rm, input logic [4:0] ef, fm);
    c(0, 0, 0, 0, 0, ra, er, rm, ef, fm);
  endfunction

  task automatic apply(input vec_t t, input int idx);
    logic [4:0] fl;
    @(negedge clk);
    exec = t.ex; ctl_load = t.ld; ctl_dec = t.dc; ctl_shift = t.sh; ser_in = t.si;
    reg_wr = t.wr; reg_addr = t.wa; reg_wdata = t.wd;
    @(posedge clk);
    #1;
    exec = 0; ctl_load = 0; ctl_dec = 0; ctl_shift = 0; reg_wr = 0; reg_addr = t.ra;
    #1;
    if (t.rm != 0 || t.fm != 0) begin
      n_run++;
      fl = {ser_out, shift_done, irq, cnt_zero};
      if (((reg_rdata ^ t.er) & t.rm) != 0 || ((fl ^ t.ef) & t.fm) != 0) begin
        n_fail++;
        $display("FAIL vec%0d addr %02h: got rdata %08h flags %05b, required rdata %08h flags %05b (masks %08h %05b)",
                 idx, t.ra, reg_rdata, fl, t.er, t.ef, t.rm, t.fm);
      end
    end
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i], i);
    tbl.delete();
  endtask

  task automatic rd_chk(input string nm, input logic [5:0] a, input logic [31:0] e);
    reg_addr = a;
    #1;
    n_run++;
    if (reg_rdata !== e) begin
      n_fail++;
      $display("FAIL %s: got %08h, required %08h", nm, reg_rdata, e);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // reset state and register-map boundaries
    r(ST, 0, M, 5'b00011, 5'b11111);
    r(C0, 0, M, 0, 0); r(C1, 0, M, 0, 0); r(CT, 0, M, 0, 0); r(SD, 0, M, 0, 0);
    w(CT, 32'h0F0F_1F01); r(CT, 32'h0303_0F01, M, 0, 0);
    w(6'h18, 32'h77); r(6'h18, 0, M, 0, 0);
    w(6'h3C, 32'h55); r(6'h3C, 0, M, 0, 0);
    w(CT, 0);
    // counter 0 load / decrement / hold at zero
    w(P0, 3); r(P0, 3, M, 0, 0);
    c(1, 2'b01, 0, 0, 0, C0, 3, M, 5'b00010, F_Z);
    c(1, 0, 2'b01, 0, 0, C0, 2, M, 5'b00010, F_Z);
    c(1, 0, 2'b01, 0, 0, C0, 1, M, 5'b00010, F_Z);
    c(1, 0, 2'b01, 0, 0, C0, 0, M, 5'b00011, F_Z);
    r(ST, 1, 32'h1F, 0, F_IRQ);
    w(ST, 1); r(ST, 0, 32'h1F, 0, 0);
    c(1, 0, 2'b01, 0, 0, C0, 0, M, 5'b00011, F_Z);
    r(ST, 0, 32'h1F, 0, 0);
    // counter 1 auto-reload and irq
    w(CT, 32'h0202_0000); w(P1, 2);
    c(1, 2'b10, 0, 0, 0, C1, 2, M, 5'b00001, F_Z);
    c(1, 0, 2'b10, 0, 0, C1, 1, M, 5'b00001, F_Z | F_IRQ);
    c(1, 0, 2'b10, 0, 0, C1, 0, M, 5'b00011, F_Z | F_IRQ);
    c(1, 0, 2'b10, 0, 0, C1, 2, M, 5'b00101, F_Z | F_IRQ);
    c(1, 0, 2'b10, 0, 0, C1, 1, M, 5'b00101, F_Z | F_IRQ);
    c(1, 0, 2'b10, 0, 0, C1, 0, M, 5'b00111, F_Z | F_IRQ);
    r(ST, 2, 32'h1F, 0, 0);
    v(0, 0, 0, 0, 0, 1, ST, 2, ST, 0, 32'h1F, F_IRQ, F_IRQ);
    r(ST, 0, 32'h1F, 0, F_IRQ);
    // MSB-first 8-bit frame
    w(CT, 32'h0000_0700);
    v(0, 0, 0, 0, 0, 1, SD, 32'hA5, SD, 32'hA5, M, F_SO, F_SO | F_SD);
    c(1, 0, 0, 1, 1, SD, 32'h014B, M, 5'b00000, F_SO | F_SD);
    c(1, 0, 0, 1, 1, SD, 32'h0297, M, 5'b10000, F_SO | F_SD);
    c(1, 0, 0, 1, 1, SD, 32'h052F, M, 5'b00000, F_SO | F_SD);
    c(1, 0, 0, 1, 1, SD, 32'h0A5F, M, 5'b00000, F_SO | F_SD);
    c(1, 0, 0, 1, 1, SD, 32'h14BF, M, 5'b10000, F_SO | F_SD);
    c(1, 0, 0, 1, 1, SD, 32'h297F, M, 5'b00000, F_SO | F_SD);
    c(1, 0, 0, 1, 1, SD, 32'h52FF, M, 5'b10000, F_SO | F_SD);
    c(1, 0, 0, 1, 1, SD, 32'h00FF, 32'hFF, 5'b11000, F_SO | F_SD);
    r(ST, 32'h10, 32'h1F1F, 0, F_SD);
    // LSB-first 4-bit frame
    w(ST, 32'h10); w(CT, 32'h0301);
    v(0, 0, 0, 0, 0, 1, SD, 3, SD, 3, M, F_SO, F_SO | F_SD);
    c(1, 0, 0, 1, 1, ST, 32'h100, 32'h1F1F, 5'b10000, F_SO | F_SD);
    c(1, 0, 0, 1, 0, ST, 32'h200, 32'h1F1F, 5'b00000, F_SO | F_SD);
    c(1, 0, 0, 1, 0, ST, 32'h300, 32'h1F1F, 5'b00000, F_SO | F_SD);
    c(1, 0, 0, 1, 1, ST, 32'h010, 32'h1F1F, 5'b11000, F_SO | F_SD);
    r(SD, 9, M, F_SO, F_SO | F_SD);
    // exec gating
    w(P0, 5);
    c(1, 2'b01, 0, 0, 0, C0, 5, M, 5'b00010, F_Z);
    c(0, 2'b11, 2'b11, 1, 1, C0, 5, M, 5'b00010, F_Z);
    r(C1, 0, M, 0, 0); r(SD, 9, M, F_SO, F_SO); r(ST, 32'h10, 32'h1F1F, 0, 0);
    // SHIFT_DATA write colliding with a shift
    c(1, 0, 0, 1, 0, ST, 32'h110, 32'h1F1F, 0, 0);
    v(1, 0, 0, 1, 1, 1, SD, 32'h1234, ST, 32'h10, 32'h1F1F, 0, 0);
    r(SD, 32'h1234, M, 0, 0);
    // W1C colliding with a counter event
    c(1, 2'b10, 0, 0, 0, C1, 2, M, 0, 0);
    c(1, 0, 2'b10, 0, 0, C1, 1, M, 0, 0);
    v(1, 0, 2'b10, 0, 0, 1, ST, 2, ST, 32'h12, 32'h1F, 0, 0);
    w(ST, 2); r(ST, 32'h10, 32'h1F, 0, 0);
    run_tbl();
    // reset in the middle of a frame with irq pending
    w(CT, 32'h0010_0301); w(SD, 0);
    c(1, 0, 0, 1, 1, ST, 32'h110, 32'h1F1F, 0, 0);
    c(1, 0, 0, 1, 1, ST, 32'h210, 32'h1F1F, 0, 0);
    c(1, 0, 0, 1, 1, ST, 32'h310, 32'h1F1F, F_IRQ, F_IRQ);
    c(1, 2'b01, 0, 0, 0, C0, 5, M, F_IRQ, F_IRQ);
    run_tbl();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    rd_chk("rst count0", C0, 0);
    rd_chk("rst count1", C1, 0);
    rd_chk("rst status", ST, 0);
    rd_chk("rst ctrl", CT, 0);
    rd_chk("rst shift_data", SD, 0);
    n_run++;
    if ({ser_out, shift_done, irq, cnt_zero} !== 5'b00011) begin
      n_fail++;
      $display("FAIL rst flags: got %05b, required 00011", {ser_out, shift_done, irq, cnt_zero});
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
